ram_capture_ctrl: RTL and testbench

Parametrised capture-to-RAM write controller for the FFT sample buffer. On a start pulse it arms, optionally waits for a threshold trigger, then writes exactly DEPTH decimated samples to consecutive RAM addresses from 0. It flags completion to the downstream frequency-separation stage and can be re-armed or aborted without a reset.

---
 rtl/ram_capture_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ram_capture_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_capture_ctrl.sv
// Capture-to-RAM write controller for the FFT sample buffer: arms on start, then
// writes DEPTH decimated samples from address 0. Threshold trigger built only with RAM_CAP_TRIG_EN.
module ram_capture_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096,
    parameter int DEC_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    input  logic [DEC_W-1:0]  decim,
    input  logic              trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              wr_done
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DEC_W-1:0]   dec_cnt_q, dec_cnt_d;
    logic [DEC_W-1:0]   decim_q, decim_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               busy_q, busy_d;
    logic               wr_done_q, wr_done_d;
    logic [DEC_W-1:0]   dec_max, dec_next;

`ifdef RAM_CAP_TRIG_EN
    logic               trig_mode_q, trig_mode_d;
    logic [DATA_W-1:0]  trig_level_q, trig_level_d;
    logic [DATA_W-1:0]  prev_q, prev_d;
    logic               prev_vld_q, prev_vld_d;
`else
    logic unused_trig;
    assign unused_trig = ^{trig_mode, trig_level};
`endif

    // A latched decim of 0 behaves as 1 (keep every sample).
    assign dec_max  = (decim_q == '0) ? DEC_W'(1) : decim_q;
    assign dec_next = (dec_cnt_q == dec_max - 1'b1) ? '0 : dec_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        dec_cnt_d = dec_cnt_q;
        decim_d   = decim_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_done_d = wr_done_q;
`ifdef RAM_CAP_TRIG_EN
        trig_mode_d  = trig_mode_q;
        trig_level_d = trig_level_q;
        prev_d       = prev_q;
        prev_vld_d   = prev_vld_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // abort in the same cycle cancels the arm request
                if (start && !abort) begin
                    wr_done_d = 1'b0;
                    addr_d    = '0;
                    wr_addr_d = '0;
                    dec_cnt_d = '0;
                    decim_d   = decim;
`ifdef RAM_CAP_TRIG_EN
                    trig_mode_d  = trig_mode;
                    trig_level_d = trig_level;
                    prev_vld_d   = 1'b0;
                    state_d      = trig_mode ? ARMED : CAPTURE;
`else
                    state_d = CAPTURE;
`endif
                end
            end
`ifdef RAM_CAP_TRIG_EN
            ARMED: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (din_valid) begin
                    if (prev_vld_q && (prev_q < trig_level_q) && (din >= trig_level_q)) begin
                        // trigger sample is the first write; decimation restarts here
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = din;
                        addr_d    = addr_q + 1'b1;
                        dec_cnt_d = dec_next;
                        state_d   = CAPTURE;
                    end else begin
                        prev_d     = din;
                        prev_vld_d = 1'b1;
                    end
                end
            end
`endif
            CAPTURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (din_valid) begin
                    dec_cnt_d = dec_next;
                    if (dec_cnt_q == '0) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = din;
                        if (addr_q == LAST_ADDR) begin
                            state_d   = DONE;
                            wr_done_d = 1'b1;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ARMED) || (state_d == CAPTURE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            dec_cnt_q <= '0;
            decim_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            wr_done_q <= 1'b0;
`ifdef RAM_CAP_TRIG_EN
            trig_mode_q  <= 1'b0;
            trig_level_q <= '0;
            prev_q       <= '0;
            prev_vld_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            dec_cnt_q <= dec_cnt_d;
            decim_q   <= decim_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            wr_done_q <= wr_done_d;
`ifdef RAM_CAP_TRIG_EN
            trig_mode_q  <= trig_mode_d;
            trig_level_q <= trig_level_d;
            prev_q       <= prev_d;
            prev_vld_q   <= prev_vld_d;
`endif
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign wr_done = wr_done_q;

endmodule

// File: tb/tb_ram_capture_ctrl.sv
// Scoreboard bench for ram_capture_ctrl (DEPTH=8): stimulus pushes expected writes,
// a negedge monitor pops and compares each wr_en beat.
module tb_ram_capture_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 8;
    localparam int DEC_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, abort, din_valid, trig_mode;
    logic [DATA_W-1:0] din, trig_level;
    logic [DEC_W-1:0]  decim;
    logic              wr_en, busy, wr_done;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    ram_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DEC_W(DEC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .din_valid(din_valid), .din(din), .decim(decim),
        .trig_mode(trig_mode), .trig_level(trig_level),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .wr_done(wr_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write", wr_addr, wr_data);
            end else begin
                mon_e = sb.pop_front();
                if (wr_addr !== mon_e.addr || wr_data !== mon_e.data ||
                    wr_done !== mon_e.last || busy !== !mon_e.last) begin
                    n_err++;
                    $display("FAIL write: got addr=%0d data=%0d done=%0b busy=%0b, required addr=%0d data=%0d done=%0b busy=%0b",
                             wr_addr, wr_data, wr_done, busy, mon_e.addr, mon_e.data, mon_e.last, !mon_e.last);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic start_cap(input logic [DEC_W-1:0] d, input logic tm, input logic [DATA_W-1:0] lvl);
        start = 1'b1; decim = d; trig_mode = tm; trig_level = lvl; din_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        din = d; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic push(input int a, input int d);
        exp_t e;
        e.addr = ADDR_W'(a);
        e.data = DATA_W'(d);
        e.last = (a == DEPTH - 1);
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 50) begin
            tick();
            t++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wr_en"},   wr_en,   0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_busy"},    busy,    0);
        check({tag, "_wr_done"}, wr_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; din_valid = 1'b0; din = '0;
        decim = 8'd1; trig_mode = 1'b0; trig_level = '0;
        idle(3);
        rst = 1'b0;
        check_reset_vals("reset");

        // decim=1 immediate: data 0..7 at addr 0..7, samples 8 and 9 dropped
        start_cap(8'd1, 1'b0, 16'd0);
        check("t1_busy_rise", busy, 1);
        for (int i = 0; i < 8; i++) push(i, i);
        for (int i = 0; i < 10; i++) send(DATA_W'(i));
        idle(2);
        drain("t1_drain");
        check("t1_done", wr_done, 1);
        check("t1_busy", busy, 0);
        check("t1_addr_hold", wr_addr, 7);

        // decim=3: keep 0,3,...,21
        start_cap(8'd3, 1'b0, 16'd0);
        for (int i = 0; i < 8; i++) push(i, 3 * i);
        for (int i = 0; i <= 30; i++) send(DATA_W'(i));
        idle(2);
        drain("t2_drain");
        check("t2_done", wr_done, 1);

        // decim=0 behaves as 1
        start_cap(8'd0, 1'b0, 16'd0);
        for (int i = 0; i < 8; i++) push(i, 50 + i);
        for (int i = 0; i < 10; i++) send(DATA_W'(50 + i));
        idle(2);
        drain("t2b_drain");

        // rising threshold at 100; first sample after arming only primes prev
        start_cap(8'd1, 1'b1, 16'd100);
        check("t3_busy", busy, 1);
`ifdef RAM_CAP_TRIG_EN
        for (int i = 0; i < 8; i++) push(i, 100 + i);
`else
        push(0, 120); push(1, 50); push(2, 99);
        for (int i = 3; i < 8; i++) push(i, 97 + i);
`endif
        send(16'd120); send(16'd50); send(16'd99);
        for (int i = 100; i <= 110; i++) send(DATA_W'(i));
        idle(2);
        drain("t3_drain");
        check("t3_done", wr_done, 1);

        // abort after 3 writes; abort beats a coincident valid sample
        start_cap(8'd1, 1'b0, 16'd0);
        push(0, 200); push(1, 201); push(2, 202);
        send(16'd200); send(16'd201); send(16'd202);
        abort = 1'b1; din = 16'd203; din_valid = 1'b1;
        tick();
        abort = 1'b0; din_valid = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_done", wr_done, 0);
        send(16'd204); send(16'd205);
        idle(1);
        check("t4_addr_hold", wr_addr, 2);
        drain("t4_drain");
        // start with abort from IDLE is dropped
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("t4_sa_busy", busy, 0);
        send(16'd206);
        idle(1);
        check("t4_sa_addr", wr_addr, 2);

        // re-arm from DONE; start during CAPTURE ignored
        start_cap(8'd1, 1'b0, 16'd0);
        for (int i = 0; i < 8; i++) push(i, 10 + i);
        for (int i = 0; i < 8; i++) send(DATA_W'(10 + i));
        idle(1);
        check("t5_done1", wr_done, 1);
        start_cap(8'd1, 1'b0, 16'd0);
        check("t5_done_drop", wr_done, 0);
        check("t5_addr_clr", wr_addr, 0);
        check("t5_busy", busy, 1);
        for (int i = 0; i < 3; i++) push(i, 30 + i);
        for (int i = 0; i < 3; i++) send(DATA_W'(30 + i));
        start_cap(8'd3, 1'b0, 16'd0);
        for (int i = 3; i < 8; i++) push(i, 30 + i);
        for (int i = 3; i < 8; i++) send(DATA_W'(30 + i));
        idle(2);
        drain("t5_drain");
        check("t5_done2", wr_done, 1);

        // async reset mid-capture with valid gaps
        start_cap(8'd1, 1'b0, 16'd0);
        push(0, 70); push(1, 71); push(2, 72);
        send(16'd70); idle(1); send(16'd71); idle(2); send(16'd72); idle(1);
        din = 16'd73; din_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_reset_vals("t6_rst");
        tick();
        rst = 1'b0; din_valid = 1'b0;
        check("t6_sb_empty", sb.size(), 0);
        send(16'd80); send(16'd81);
        idle(2);
        check("t6_busy", busy, 0);
        check("t6_done", wr_done, 0);
        check("t6_wr_en", wr_en, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
